// File: rtl/uart_rx_cmd_loader.sv
// ASCII write-command parser: "<a|b|c|p><ND hex digits><LF|CR>" loads a register-file entry.
// Define UART_RX_CMD_ECHO_EN to add a one-cycle-delayed echo of every accepted byte.
module uart_rx_cmd_loader #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_wr_en,
  output logic [7:0]        o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_err,
  output logic              o_busy
`ifdef UART_RX_CMD_ECHO_EN
  ,
  output logic [7:0]        o_echo_byte,
  output logic              o_echo_valid
`endif
);

  localparam int ND    = DATA_W / 4;
  localparam int CNT_W = $clog2(ND + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(ND - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIGITS  = 2'd1;
  localparam logic [1:0] ST_WAIT_NL = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [7:0]        addr_hold_reg, addr_hold_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  digit_cnt_reg, digit_cnt_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic              wr_en_reg;
  logic [7:0]        wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              err_reg;
  logic              err_next;
  logic              commit;

  logic              is_hex;
  logic [3:0]        nibble;
  logic              is_nl;
  logic              is_letter;

  // Digits map via their low nibble; letters a-f/A-F share low nibbles 1..6.
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'd0;
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      nibble = i_byte[3:0];
    end else if ((i_byte >= 8'h61 && i_byte <= 8'h66) ||
                 (i_byte >= 8'h41 && i_byte <= 8'h46)) begin
      nibble = i_byte[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  assign is_nl     = (i_byte == 8'h0A) || (i_byte == 8'h0D);
  assign is_letter = (i_byte == 8'h61) || (i_byte == 8'h62) ||
                     (i_byte == 8'h63) || (i_byte == 8'h70);

  always_comb begin
    state_next     = state_reg;
    addr_hold_next = addr_hold_reg;
    shift_next     = shift_reg;
    digit_cnt_next = digit_cnt_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    err_next       = 1'b0;
    commit         = 1'b0;
    if (i_byte_valid) begin
      // A byte always wins over a timeout expiring in the same cycle.
      tmo_cnt_next = '0;
      case (state_reg)
        ST_IDLE: begin
          if (is_letter) begin
            addr_hold_next = i_byte;
            shift_next     = '0;
            digit_cnt_next = '0;
            state_next     = ST_DIGITS;
          end else if (!is_nl) begin
            err_next = 1'b1;
          end
        end
        ST_DIGITS: begin
          if (is_hex) begin
            shift_next     = (shift_reg << 4) | DATA_W'(nibble);
            digit_cnt_next = digit_cnt_reg + CNT_W'(1);
            if (digit_cnt_reg == LAST_DIGIT) begin
              state_next = ST_WAIT_NL;
            end
          end else if (is_nl) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_DRAIN;
          end
        end
        ST_WAIT_NL: begin
          if (is_nl) begin
            commit     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_DRAIN;
          end
        end
        default: begin
          if (is_nl) begin
            state_next = ST_IDLE;
          end
        end
      endcase
    end else if (state_reg != ST_IDLE) begin
      if (tmo_cnt_reg == TMO_LAST) begin
        tmo_cnt_next = '0;
        state_next   = ST_IDLE;
        err_next     = (state_reg != ST_DRAIN);
      end else begin
        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
      end
    end else begin
      tmo_cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      addr_hold_reg <= '0;
      shift_reg     <= '0;
      digit_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_hold_reg <= addr_hold_next;
      shift_reg     <= shift_next;
      digit_cnt_reg <= digit_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      wr_en_reg     <= commit;
      err_reg       <= err_next;
      if (commit) begin
        wr_addr_reg <= addr_hold_reg;
        wr_data_reg <= shift_reg;
      end
    end
  end

  assign o_wr_en   = wr_en_reg;
  assign o_wr_addr = wr_addr_reg;
  assign o_wr_data = wr_data_reg;
  assign o_err     = err_reg;
  assign o_busy    = (state_reg != ST_IDLE);

`ifdef UART_RX_CMD_ECHO_EN
  logic [7:0] echo_byte_reg;
  logic       echo_valid_reg;
  logic [7:0] folded;

  assign folded = (i_byte >= 8'h41 && i_byte <= 8'h46) ? (i_byte | 8'h20) : i_byte;

  // Without a valid byte, err_next can only come from a timeout, which echoes '?' alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      echo_byte_reg  <= '0;
      echo_valid_reg <= 1'b0;
    end else begin
      echo_valid_reg <= i_byte_valid | err_next;
      echo_byte_reg  <= err_next ? 8'h3F : folded;
    end
  end

  assign o_echo_byte  = echo_byte_reg;
  assign o_echo_valid = echo_valid_reg;
`endif

endmodule

// File: tb/tb_uart_rx_cmd_loader.sv
// Bench for uart_rx_cmd_loader: directed command strings plus random traffic,
// checked every cycle against a line-buffer model of the command grammar.
module tb_uart_rx_cmd_loader;

  localparam int DATA_W = 32;
  localparam int ND     = DATA_W / 4;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              err;
  logic              busy;
`ifdef UART_RX_CMD_ECHO_EN
  logic [7:0]        echo_byte;
  logic              echo_valid;
`endif

  uart_rx_cmd_loader #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_byte       (in_byte),
    .i_byte_valid (in_valid),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_err        (err),
    .o_busy       (busy)
`ifdef UART_RX_CMD_ECHO_EN
    ,
    .o_echo_byte  (echo_byte),
    .o_echo_valid (echo_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the pending command is kept as text and only evaluated at the newline.
  logic [7:0]        m_letter;
  byte unsigned      m_digits[$];
  logic              m_active;
  logic              m_dead;
  int                m_quiet;
  logic              exp_wr;
  logic              exp_err;
  logic              exp_busy;
  logic [7:0]        exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              exp_echo_v;
  logic [7:0]        exp_echo_b;

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return -1;
  endfunction

  function automatic logic [7:0] lower(input logic [7:0] b);
    return (b >= "A" && b <= "F") ? b + 8'd32 : b;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_active   = 1'b0;
    m_dead     = 1'b0;
    m_quiet    = 0;
    exp_wr     = 1'b0;
    exp_err    = 1'b0;
    exp_busy   = 1'b0;
    exp_addr   = '0;
    exp_data   = '0;
    exp_echo_v = 1'b0;
    exp_echo_b = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    logic nl;
    exp_wr     = 1'b0;
    exp_err    = 1'b0;
    exp_echo_v = 1'b0;
    if (v) begin
      m_quiet    = 0;
      exp_echo_v = 1'b1;
      nl = (b == 8'h0A) || (b == 8'h0D);
      if (m_dead) begin
        if (nl) m_dead = 1'b0;
      end else if (!m_active) begin
        if (b == "a" || b == "b" || b == "c" || b == "p") begin
          m_active = 1'b1;
          m_letter = b;
          m_digits.delete();
        end else if (!nl) begin
          exp_err = 1'b1;
        end
      end else if (nl) begin
        if (m_digits.size() == ND) begin
          exp_wr   = 1'b1;
          exp_addr = m_letter;
          exp_data = '0;
          foreach (m_digits[k]) exp_data = exp_data * 16 + DATA_W'(hexval(m_digits[k]));
        end else begin
          exp_err = 1'b1;
        end
        m_active = 1'b0;
      end else if (hexval(b) >= 0 && m_digits.size() < ND) begin
        m_digits.push_back(b);
      end else begin
        exp_err  = 1'b1;
        m_active = 1'b0;
        m_dead   = 1'b1;
      end
      exp_echo_b = exp_err ? 8'h3F : lower(b);
    end else if (m_active || m_dead) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        if (!m_dead) begin
          exp_err    = 1'b1;
          exp_echo_v = 1'b1;
          exp_echo_b = 8'h3F;
        end
        m_active = 1'b0;
        m_dead   = 1'b0;
        m_quiet  = 0;
      end
    end else begin
      m_quiet = 0;
    end
    exp_busy = m_active || m_dead;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, " wr_en"}, DATA_W'(wr_en), DATA_W'(exp_wr));
    chk({where, " err"}, DATA_W'(err), DATA_W'(exp_err));
    chk({where, " busy"}, DATA_W'(busy), DATA_W'(exp_busy));
    chk({where, " wr_addr"}, DATA_W'(wr_addr), DATA_W'(exp_addr));
    chk({where, " wr_data"}, wr_data, exp_data);
`ifdef UART_RX_CMD_ECHO_EN
    chk({where, " echo_valid"}, DATA_W'(echo_valid), DATA_W'(exp_echo_v));
    if (exp_echo_v) chk({where, " echo_byte"}, DATA_W'(echo_byte), DATA_W'(exp_echo_b));
`endif
  endtask

  // One clock cycle: drive, predict, clock, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] b);
    in_valid = v;
    in_byte  = v ? b : 8'h00;
    model_step(v, b);
    @(posedge clk);
    #1;
    check_outputs(v ? $sformatf("byte %02h", b) : "idle");
    $display("cycle t=%0t valid=%0b byte=%02h wr_en=%0b addr=%02h data=%08h err=%0b busy=%0b",
             $time, v, b, wr_en, wr_addr, wr_data, err, busy);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic rand_command();
    int kind;
    int nd;
    logic [7:0] letters[4];
    letters = '{8'h61, 8'h62, 8'h63, 8'h70};
    kind = int'($urandom_range(0, 9));
    if (kind == 9) begin
      step(1'b1, 8'($urandom_range(0, 255)));
      return;
    end
    nd = (kind == 6) ? int'($urandom_range(0, ND - 1)) : (kind == 7) ? ND + 1 : ND;
    step(1'b1, letters[$urandom_range(0, 3)]);
    for (int i = 0; i < nd; i++) begin
      int d;
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      d = int'($urandom_range(0, 15));
      if (kind == 8 && i == 3) step(1'b1, "x");
      else if (d < 10) step(1'b1, 8'(48 + d));
      else step(1'b1, ($urandom_range(0, 1) == 1) ? 8'(55 + d) : 8'(87 + d));
    end
    if (kind == 5 && $urandom_range(0, 1) == 1) idle(TMO + 2);
    step(1'b1, ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D);
    idle(int'($urandom_range(0, 2)));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send_str("a1234abcd\n");
    idle(2);

    send_str("pDEADBEEF");
    step(1'b1, 8'h0D);
    idle(1);

    send_str("c12g45678\n");
    send_str("b00000001\n");

    send_str("a123\n");
    send_str("a123456789\n");
    idle(1);

    send_str("b12");
    idle(20);
    send_str("b00000002\n");

    // Byte arriving on the expiry cycle keeps the command alive.
    send_str("b12");
    idle(TMO - 1);
    send_str("345678\n");

    send_str("a1234");
    step(1'b1, 8'h5A);
    idle(TMO + 2);
    send_str("\n\nz");

    send_str("c1234");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_str("c0000ffff\n");
    idle(2);

    for (int n = 0; n < 60; n++) rand_command();
    idle(TMO + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
